// File: rtl/ps_window_if.sv
// Pixel-in / 3-row-window-out bundle for ps_window_ctrl.
interface ps_window_if;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        o_ready;
    logic        i_ready;
    logic        i_flush;
    logic [23:0] o_r0_data;
    logic [23:0] o_r1_data;
    logic [23:0] o_r2_data;
    logic        o_valid;

    modport slave (
        input  i_data, i_valid, i_ready, i_flush,
        output o_ready, o_r0_data, o_r1_data, o_r2_data, o_valid
    );

    modport master (
        output i_data, i_valid, i_ready, i_flush,
        input  o_ready, o_r0_data, o_r1_data, o_r2_data, o_valid
    );
endinterface

// File: rtl/ps_window_ctrl.sv
// Line-buffer controller: stores raster lines in four rotating buffers and
// replays three complete lines column by column as 3x3 row windows.
module ps_window_ctrl #(
    parameter int unsigned LINE_W = 640,
    parameter int unsigned ADDR_W = 10
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    ps_window_if.slave bus
);
    localparam int unsigned       DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(LINE_W - 1);
    localparam logic [ADDR_W-1:0] WIN_COL0  = ADDR_W'(2);
    localparam logic [2:0]        LINES_MAX = 3'd4;

    typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [1:0]        wr_sel_q, wr_sel_d;
    logic [1:0]        rd_sel_q, rd_sel_d;
    logic [ADDR_W-1:0] wr_col_q, wr_col_d;
    logic [ADDR_W-1:0] rd_col_q, rd_col_d;
    logic [ADDR_W-1:0] ret_col_q, ret_col_d;
    logic [2:0]        lines_q, lines_d;
    logic              ready_q, ready_d;
    logic              ret_vld_q, ret_vld_d;
    logic              valid_q, valid_d;
    logic [2:0][15:0]  hist_q, hist_d;
    logic [2:0][23:0]  win_q, win_d;
    logic [2:0][7:0]   rd_pix_q;
    logic [7:0]        lb_mem [4][DEPTH];

    logic accept, line_done, issue, retire, start;

    // Per-cycle events on the write and read sides.
    always_comb begin
        accept    = bus.i_valid && ready_q;
        line_done = accept && (wr_col_q == LAST_COL);
        issue     = (state_q == READ) && bus.i_ready;
        retire    = issue && (rd_col_q == LAST_COL);
        start     = (state_q == IDLE) && (lines_q >= 3'd3) && bus.i_ready;
    end

    // Next-state: write pointer, line count, read FSM and window pipeline.
    always_comb begin
        state_d   = state_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        wr_col_d  = wr_col_q;
        rd_col_d  = rd_col_q;
        lines_d   = lines_q;
        ret_vld_d = issue;
        ret_col_d = rd_col_q;
        hist_d    = hist_q;
        win_d     = win_q;

        if (accept) begin
            if (line_done) begin
                wr_col_d = '0;
                wr_sel_d = wr_sel_q + 2'd1;
            end else begin
                wr_col_d = wr_col_q + ADDR_W'(1);
            end
        end

        case ({line_done, retire})
            2'b10:   lines_d = lines_q + 3'd1;
            2'b01:   lines_d = lines_q - 3'd1;
            default: lines_d = lines_q;
        endcase
        ready_d = (lines_d != LINES_MAX);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = READ;
                    rd_col_d = '0;
                end
            end
            READ: begin
                if (issue) begin
                    if (retire) begin
                        state_d  = IDLE;
                        rd_col_d = '0;
                        rd_sel_d = rd_sel_q + 2'd1;
                    end else begin
                        rd_col_d = rd_col_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A window needs two earlier columns of the same line behind it.
        valid_d = ret_vld_q && (ret_col_q >= WIN_COL0);
        for (int r = 0; r < 3; r++) begin
            if (start) begin
                hist_d[r] = '0;
            end else if (ret_vld_q) begin
                hist_d[r] = {hist_q[r][7:0], rd_pix_q[r]};
            end
            if (valid_d) begin
                win_d[r] = {hist_q[r], rd_pix_q[r]};
            end
        end
    end

    // State registers; flush restarts the frame exactly like reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn || bus.i_flush) begin
            state_q   <= IDLE;
            wr_sel_q  <= '0;
            rd_sel_q  <= '0;
            wr_col_q  <= '0;
            rd_col_q  <= '0;
            ret_col_q <= '0;
            lines_q   <= '0;
            ready_q   <= 1'b1;
            ret_vld_q <= 1'b0;
            valid_q   <= 1'b0;
            hist_q    <= '0;
            win_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            wr_col_q  <= wr_col_d;
            rd_col_q  <= rd_col_d;
            ret_col_q <= ret_col_d;
            lines_q   <= lines_d;
            ready_q   <= ready_d;
            ret_vld_q <= ret_vld_d;
            valid_q   <= valid_d;
            hist_q    <= hist_d;
            win_q     <= win_d;
        end
    end

    // Line-buffer RAM: one write port, three registered read lanes.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb_mem[wr_sel_q][wr_col_q] <= bus.i_data;
        end
        for (int r = 0; r < 3; r++) begin
            rd_pix_q[r] <= lb_mem[rd_sel_q + 2'(r)][rd_col_q];
        end
    end

    assign bus.o_ready   = ready_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_r0_data = win_q[0];
    assign bus.o_r1_data = win_q[1];
    assign bus.o_r2_data = win_q[2];
endmodule

// File: tb/tb_ps_window_ctrl.sv
// Self-checking bench for ps_window_ctrl with LINE_W=8.
module tb_ps_window_ctrl;
    localparam int unsigned LW   = 8;
    localparam int unsigned AW   = 3;
    localparam int          NWIN = int'(LW) - 2;

    typedef struct packed { logic [23:0] r0, r1, r2; } win_t;
    typedef struct packed { win_t w; logic skid_ok; } obs_t;
    typedef struct { int col; win_t exp; } vec_t;
    typedef logic [LW-1:0][7:0] line_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    ps_window_if bus();

    ps_window_ctrl #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   obs_cur  = 0;
    int   exp_cur  = 0;
    int   pix_next = 0;
    vec_t tbl [NWIN];

    // Reference model: whole lines in, every 3 consecutive lines -> LW-2 windows.
    win_t       exp_q[$];
    obs_t       obs_q[$];
    line_t      done_lines[$];
    line_t      cur_line;
    int         cur_col  = 0;
    logic [1:0] rdy_hist = 2'b00;

    function automatic logic [23:0] pack3(input line_t l, input int c);
        return {l[c-2], l[c-1], l[c]};
    endfunction

    always @(negedge clk) begin
        obs_t o;
        win_t w;
        if (!rstn || bus.i_flush) begin
            exp_q.delete();
            obs_q.delete();
            done_lines.delete();
            cur_col = 0;
        end else begin
            if (bus.o_valid) begin
                o.w.r0    = bus.o_r0_data;
                o.w.r1    = bus.o_r1_data;
                o.w.r2    = bus.o_r2_data;
                o.skid_ok = rdy_hist[1];
                obs_q.push_back(o);
            end
            if (bus.i_valid && bus.o_ready) begin
                cur_line[cur_col] = bus.i_data;
                cur_col++;
                if (cur_col == int'(LW)) begin
                    cur_col = 0;
                    done_lines.push_back(cur_line);
                    if (done_lines.size() == 3) begin
                        for (int c = 2; c < int'(LW); c++) begin
                            w.r0 = pack3(done_lines[0], c);
                            w.r1 = pack3(done_lines[1], c);
                            w.r2 = pack3(done_lines[2], c);
                            exp_q.push_back(w);
                        end
                        void'(done_lines.pop_front());
                    end
                end
            end
        end
        rdy_hist = {rdy_hist[0], bus.i_ready};
    end

    function automatic logic [7:0] pat(input int k);
        return 8'(((k / int'(LW)) % 16) * 16 + (k % int'(LW)));
    endfunction

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_win(input string name, input win_t act, input win_t req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got r0=%06h r1=%06h r2=%06h, expected r0=%06h r1=%06h r2=%06h",
                     name, act.r0, act.r1, act.r2, req.r0, req.r1, req.r2);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        bus.i_valid = v;
        bus.i_data  = d;
        bus.i_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_data  = '0;
        rstn        = 1'b0;
        @(posedge clk);
        #1;
        rstn     = 1'b1;
        obs_cur  = 0;
        exp_cur  = 0;
        pix_next = 0;
    endtask

    task automatic do_flush();
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        obs_cur  = 0;
        exp_cur  = 0;
        pix_next = 0;
    endtask

    // rmode: 0 ready low, 1 ready high, 2 toggle every 3 cycles, 3 random.
    task automatic drive(input int n_pix, input int rmode, input bit rnd,
                         input int budget, input string name);
        int   sent;
        int   cyc;
        logic v;
        logic r;
        logic acc;
        sent = 0;
        cyc  = 0;
        while ((sent < n_pix || (obs_q.size() - obs_cur) < (exp_q.size() - exp_cur))
               && cyc < budget) begin
            v = (sent < n_pix) && (!rnd || $urandom_range(0, 3) != 0);
            case (rmode)
                0:       r = 1'b0;
                1:       r = 1'b1;
                2:       r = ((cyc / 3) % 2) == 0;
                default: r = 1'($urandom_range(0, 1));
            endcase
            acc = v && bus.o_ready;
            step(v, rnd ? 8'($urandom) : pat(pix_next), r);
            if (acc) begin
                sent++;
                pix_next++;
            end
            cyc++;
        end
        check_int({name, " finished in budget"}, int'(cyc < budget), 1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic compare_windows(input string name);
        check_int({name, " window count"}, obs_q.size() - obs_cur, exp_q.size() - exp_cur);
        while (obs_cur < obs_q.size() && exp_cur < exp_q.size()) begin
            check_win({name, " window"}, obs_q[obs_cur].w, exp_q[exp_cur]);
            check_int({name, " skid bound"}, int'(obs_q[obs_cur].skid_ok), 1);
            obs_cur++;
            exp_cur++;
        end
        obs_cur = obs_q.size();
        exp_cur = exp_q.size();
    endtask

    task automatic check_table(input string name);
        for (int i = 0; i < NWIN; i++) begin
            if (obs_cur + i < obs_q.size()) begin
                check_win($sformatf("%s col %0d", name, tbl[i].col), obs_q[obs_cur + i].w, tbl[i].exp);
            end else begin
                n_checks++;
                n_fail++;
                $display("FAIL %s col %0d: window missing, expected r0=%06h",
                         name, tbl[i].col, tbl[i].exp.r0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Expected windows for rows 0..2 of the row*16+col pattern.
        for (int c = 2; c < int'(LW); c++) begin
            tbl[c-2].col    = c;
            tbl[c-2].exp.r0 = {8'(c - 2), 8'(c - 1), 8'(c)};
            tbl[c-2].exp.r1 = tbl[c-2].exp.r0 + 24'h101010;
            tbl[c-2].exp.r2 = tbl[c-2].exp.r0 + 24'h202020;
        end

        // 1: reset state and idle.
        do_reset();
        check_int("t1 o_valid", int'(bus.o_valid), 0);
        check_int("t1 o_ready", int'(bus.o_ready), 1);
        check_int("t1 o_r0", int'(bus.o_r0_data), 0);
        check_int("t1 o_r1", int'(bus.o_r1_data), 0);
        check_int("t1 o_r2", int'(bus.o_r2_data), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        check_int("t1 idle o_valid", int'(bus.o_valid), 0);

        // 2: three lines, ready high; first window 4 cycles after READ entry.
        for (int k = 0; k < 3 * int'(LW); k++) step(1'b1, pat(k), 1'b1);
        n = 0;
        while (!bus.o_valid && n < 20) begin
            step(1'b0, 8'h00, 1'b1);
            n++;
        end
        check_int("t2 first window latency", n, 5);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
        check_table("t2");
        compare_windows("t2");

        // 3: ready low, four lines fill every buffer; 33rd pixel waits for a retire.
        do_reset();
        for (int k = 0; k < 4 * int'(LW); k++) step(1'b1, pat(k), 1'b0);
        check_int("t3 o_ready after 32 px", int'(bus.o_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, pat(32), 1'b0);
            check_int("t3 33rd held", int'(bus.o_ready), 0);
        end
        n = 0;
        while (!bus.o_ready && n < 40) begin
            step(1'b1, pat(32), 1'b1);
            n++;
        end
        check_int("t3 cycles to o_ready", n, 9);
        step(1'b1, pat(32), 1'b1);
        pix_next = 33;
        drive(7, 1, 1'b0, 500, "t3");
        compare_windows("t3");

        // 4: six lines, i_ready toggling every 3 cycles.
        do_reset();
        drive(6 * int'(LW), 2, 1'b0, 2000, "t4");
        check_int("t4 total windows", obs_q.size() - obs_cur, 4 * NWIN);
        compare_windows("t4");

        // 5: retire coincides with line complete; count stays at 3.
        do_reset();
        for (int k = 0; k < 3 * int'(LW); k++) step(1'b1, pat(k), 1'b1);
        step(1'b0, 8'h00, 1'b1);
        for (int k = 3 * int'(LW); k < 4 * int'(LW); k++) begin
            check_int("t5 o_ready during line 3", int'(bus.o_ready), 1);
            step(1'b1, pat(k), 1'b1);
        end
        check_int("t5 o_ready after retire+complete", int'(bus.o_ready), 1);
        step(1'b0, 8'h00, 1'b0);
        for (int k = 4 * int'(LW); k < 5 * int'(LW); k++) step(1'b1, pat(k), 1'b0);
        check_int("t5 o_ready after one more line", int'(bus.o_ready), 0);
        pix_next = 5 * int'(LW);
        drive(0, 1, 1'b0, 500, "t5");
        compare_windows("t5");

        // 6: reset mid-READ after window 3, then re-stream.
        do_reset();
        for (int k = 0; k < 3 * int'(LW); k++) step(1'b1, pat(k), 1'b1);
        n = 0;
        while ((obs_q.size() - obs_cur) < 3 && n < 40) begin
            step(1'b0, 8'h00, 1'b1);
            n++;
        end
        check_int("t6 windows before reset", obs_q.size() - obs_cur, 3);
        do_reset();
        check_int("t6 o_valid after reset", int'(bus.o_valid), 0);
        check_int("t6 o_ready after reset", int'(bus.o_ready), 1);
        drive(3 * int'(LW), 1, 1'b0, 500, "t6");
        check_table("t6");
        compare_windows("t6");

        // Flush mid-line discards the partial line.
        for (int k = 0; k < 5; k++) step(1'b1, 8'(8'hA0 + k), 1'b0);
        do_flush();
        check_int("flush o_valid", int'(bus.o_valid), 0);
        check_int("flush o_ready", int'(bus.o_ready), 1);
        drive(3 * int'(LW), 1, 1'b0, 500, "flush");
        check_table("flush");
        compare_windows("flush");

        // Randomized data, valid gaps and ready against the model.
        do_reset();
        drive(12 * int'(LW), 3, 1'b1, 4000, "rand");
        compare_windows("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
